fetch_ctrl: RTL

Instruction-fetch sequencer for the core: owns the program counter, issues one request at a time to instruction memory over a req/ack handshake, and presents each returned instruction to decode over a valid/ready handshake. Decode resolves each instruction and returns the next-PC decision (sequential, branch, or halt) as it accepts it. The block sits between the instruction memory and the decode stage, and provides the PC sequencing that the standalone PC register only stores.

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-side buses: instruction-memory req/ack and decode valid/ready with next-PC decision.
interface fetch_ctrl_if #(
  parameter int IW  = 8,
  parameter int IMW = 4
);
  logic           imem_req;
  logic [IMW-1:0] imem_addr;
  logic           imem_ack;
  logic [IW-1:0]  imem_data;
  logic [IW-1:0]  instr;
  logic [IMW-1:0] instr_pc;
  logic           instr_valid;
  logic           instr_ready;
  logic           branch_taken;
  logic [IMW-1:0] branch_target;
  logic           halt;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_data, instr_ready, branch_taken, branch_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_data, instr_ready, branch_taken, branch_target, halt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches one word at a time and holds it for decode
// until decode accepts it together with the next-PC decision.
module fetch_ctrl #(
  parameter int IW  = 8,
  parameter int IMW = 4,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  fetch_ctrl_if.master  bus,
  output logic          busy_o,
  output logic [CW-1:0] retired_o
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} state_e;

  state_e         state_q;
  logic [IMW-1:0] pc_q, pc_d;
  logic [IW-1:0]  instr_q;
  logic [IMW-1:0] instr_pc_q;
  logic [CW-1:0]  retired_q, retired_d;

  // Next PC is only consumed on a decode handshake, so branch inputs are otherwise don't-care.
  always_comb begin
    pc_d = pc_q + 1'b1;
    if (bus.branch_taken) pc_d = bus.branch_target;
  end

  assign retired_d = (&retired_q) ? retired_q : retired_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      retired_q  <= '0;
    end else begin
      case (state_q)
        IDLE, HALTED: begin
          if (start_i) begin
            pc_q      <= '0;
            retired_q <= '0;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            instr_q    <= bus.imem_data;
            instr_pc_q <= pc_q;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            retired_q <= retired_d;
            // halt wins over a simultaneous branch and leaves pc where it was
            if (bus.halt) begin
              state_q <= HALTED;
            end else begin
              pc_q    <= pc_d;
              state_q <= REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake strobes come straight off the state register, never from inputs.
  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign busy_o          = (state_q == REQ) || (state_q == HOLD);
  assign retired_o       = retired_q;
endmodule
